// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: fetches the instruction at pc_i over a req/ack handshake, presents it
// to the core and computes the next PC (sequential or redirect) for the PC register.
module inst_fetch_unit #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic [ADDR_W-1:0] pc_next_o,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [DATA_W-1:0] imem_rdata_i,
   output logic [DATA_W-1:0] instr_o,
   output logic              instr_valid_o,
   input  logic              core_ready_i,
   input  logic              branch_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic              fault_o,
   output logic [1:0]        fault_cause_o,
   output logic [31:0]       retired_cnt_o
);

   localparam logic [7:0] TimeoutCnt  = 8'(TIMEOUT);
   localparam logic [1:0] CauseAlign  = 2'b01;
   localparam logic [1:0] CauseTimout = 2'b10;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StValid,
      StFault
   } state_e;

   state_e              state_q, state_d;
   logic [7:0]          wait_q, wait_d;
   logic [DATA_W-1:0]   instr_q, instr_d;
   logic                valid_q, valid_d;
   logic                fault_q, fault_d;
   logic [1:0]          cause_q, cause_d;
   logic [31:0]         retired_q, retired_d;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= StIdle;
         wait_q    <= '0;
         instr_q   <= '0;
         valid_q   <= 1'b0;
         fault_q   <= 1'b0;
         cause_q   <= 2'b00;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         fault_q   <= fault_d;
         cause_q   <= cause_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      instr_d     = instr_q;
      valid_d     = valid_q;
      fault_d     = fault_q;
      cause_d     = cause_q;
      retired_d   = retired_q;
      imem_req_o  = 1'b0;
      imem_addr_o = '0;
      pc_next_o   = pc_i;

      unique case (state_q)
         StIdle: begin
            wait_d  = '0;
            state_d = StReq;
         end

         StReq: begin
            if (pc_i[1:0] != 2'b00) begin
               // Misaligned PC faults without ever touching memory.
               fault_d = 1'b1;
               cause_d = CauseAlign;
               state_d = StFault;
            end else begin
               imem_req_o  = 1'b1;
               imem_addr_o = pc_i;
               if (imem_ack_i) begin
                  // Ack beats a timeout landing in the same cycle.
                  instr_d = imem_rdata_i;
                  valid_d = 1'b1;
                  state_d = StValid;
               end else if (wait_q == TimeoutCnt) begin
                  fault_d = 1'b1;
                  cause_d = CauseTimout;
                  state_d = StFault;
               end else begin
                  wait_d = wait_q + 8'd1;
               end
            end
         end

         StValid: begin
            if (core_ready_i) begin
               pc_next_o = branch_i ? branch_target_i : pc_i + ADDR_W'(4);
               retired_d = retired_q + 32'd1;
               valid_d   = 1'b0;
               wait_d    = '0;
               state_d   = StReq;
            end
         end

         StFault: begin
            state_d = StFault;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign instr_o       = instr_q;
   assign instr_valid_o = valid_q;
   assign fault_o       = fault_q;
   assign fault_cause_o = cause_q;
   assign retired_cnt_o = retired_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized scoreboard bench for inst_fetch_unit: a program-flow reference model predicts the
// fetch addresses and accepted instructions, followed by directed fault and reset scenarios.
module tb_inst_fetch_unit;

   localparam int NTX = 40;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] pc_i;
   logic [31:0] pc_next_o;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic [31:0] instr_o;
   logic        instr_valid_o;
   logic        core_ready_i = 1'b0;
   logic        branch_i = 1'b0;
   logic [31:0] branch_target_i = '0;
   logic        fault_o;
   logic [1:0]  fault_cause_o;
   logic [31:0] retired_cnt_o;

   always #5 clk_i = ~clk_i;

   inst_fetch_unit #(
      .ADDR_W (32),
      .DATA_W (32),
      .TIMEOUT(4)
   ) u_dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .pc_i           (pc_i),
      .pc_next_o      (pc_next_o),
      .imem_req_o     (imem_req_o),
      .imem_addr_o    (imem_addr_o),
      .imem_ack_i     (imem_ack_i),
      .imem_rdata_i   (imem_rdata_i),
      .instr_o        (instr_o),
      .instr_valid_o  (instr_valid_o),
      .core_ready_i   (core_ready_i),
      .branch_i       (branch_i),
      .branch_target_i(branch_target_i),
      .fault_o        (fault_o),
      .fault_cause_o  (fault_cause_o),
      .retired_cnt_o  (retired_cnt_o)
   );

   // External PC register: loads pc_next_o every clock.
   logic [31:0] pc_q;
   logic [31:0] pc_rst = '0;
   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) pc_q <= pc_rst;
      else        pc_q <= pc_next_o;
   end
   assign pc_i = pc_q;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction table and expected-response queues.
   logic [31:0] tx_data[NTX];
   logic [31:0] tx_tgt[NTX];
   logic        tx_br[NTX];
   int          tx_lat[NTX];
   int          tx_rdy[NTX];

   typedef struct {
      logic [31:0] instr;
      logic [31:0] next;
      logic [31:0] retired;
   } acc_t;

   logic [31:0] exp_addr_q[$];
   acc_t        exp_acc_q[$];

   bit auto = 1'b0;
   int n_acc = 0;

   // Memory responder: acks each fetch after its table latency; random junk acks elsewhere.
   initial begin
      int mi = 0;
      int mw = 0;
      forever begin
         @(posedge clk_i);
         #1;
         if (auto) begin
            imem_ack_i = 1'b0;
            if (imem_req_o) begin
               if (mi < NTX && mw == tx_lat[mi]) begin
                  imem_ack_i   = 1'b1;
                  imem_rdata_i = tx_data[mi];
                  mi++;
                  mw = 0;
               end else begin
                  mw++;
               end
            end else begin
               imem_ack_i   = 1'($urandom_range(0, 1));
               imem_rdata_i = $urandom;
            end
         end
      end
   end

   // Core driver: stalls each instruction per table, then accepts with its branch decision.
   initial begin
      int ci = 0;
      int cw = 0;
      forever begin
         @(posedge clk_i);
         #1;
         if (auto) begin
            core_ready_i    = 1'b0;
            branch_i        = 1'($urandom_range(0, 1));
            branch_target_i = $urandom;
            if (instr_valid_o && ci < NTX) begin
               if (cw == tx_rdy[ci]) begin
                  core_ready_i    = 1'b1;
                  branch_i        = tx_br[ci];
                  branch_target_i = tx_tgt[ci];
                  ci++;
                  cw = 0;
               end else begin
                  cw++;
               end
            end
         end
      end
   end

   // Monitor: compares DUT responses against the queued predictions.
   always @(negedge clk_i) begin
      if (auto && rst_i) begin
         if (imem_req_o && imem_ack_i) begin
            if (exp_addr_q.size() == 0) check("addr_underflow", 1, 0);
            else check("imem_addr", imem_addr_o, exp_addr_q.pop_front());
         end
         if (imem_req_o && !imem_ack_i) check("pc_next_wait", pc_next_o, pc_i);
         if (instr_valid_o && !core_ready_i) check("pc_next_stall", pc_next_o, pc_i);
         if (instr_valid_o && core_ready_i) begin
            if (exp_acc_q.size() == 0) begin
               check("acc_underflow", 1, 0);
            end else begin
               acc_t e;
               e = exp_acc_q.pop_front();
               check("instr", instr_o, e.instr);
               check("pc_next_accept", pc_next_o, e.next);
               check("retired_before", retired_cnt_o, e.retired);
            end
            n_acc++;
         end
         if (fault_o && n_acc < NTX) check("fault_during_run", fault_o, 0);
      end
   end

   task automatic do_reset(input logic [31:0] p);
      @(posedge clk_i);
      #1;
      pc_rst = p;
      rst_i  = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
   endtask

   initial begin
      logic [31:0] addr;
      logic [31:0] nxt;
      int          cnt;
      bit          done;

      // Reset values.
      #2 rst_i = 1'b0;
      #1;
      check("rst_req", imem_req_o, 0);
      check("rst_addr", imem_addr_o, 0);
      check("rst_instr", instr_o, 0);
      check("rst_valid", instr_valid_o, 0);
      check("rst_fault", fault_o, 0);
      check("rst_cause", fault_cause_o, 0);
      check("rst_retired", retired_cnt_o, 0);
      check("rst_pc_next", pc_next_o, pc_i);

      // Build the program and predict the fetch stream from the control-flow rules.
      for (int i = 0; i < NTX; i++) begin
         tx_data[i] = $urandom;
         tx_lat[i]  = $urandom_range(0, 4);
         tx_rdy[i]  = $urandom_range(0, 3);
         tx_br[i]   = ($urandom_range(0, 3) == 0);
         tx_tgt[i]  = {22'd0, 8'($urandom), 2'b00};
      end
      for (int i = 0; i < 3; i++) begin
         tx_lat[i] = 0;
         tx_rdy[i] = 0;
         tx_br[i]  = 1'b0;
      end
      tx_lat[3] = 3; tx_data[3] = 32'h8C22_0004;
      tx_lat[4] = 4;
      tx_rdy[5] = 5;  tx_br[5] = 1'b1; tx_tgt[5] = 32'h0000_0040;
      tx_br[8]  = 1'b1; tx_tgt[8] = 32'hFFFF_FFFC;
      tx_br[9]  = 1'b0;
      addr = 32'h0;
      for (int i = 0; i < NTX; i++) begin
         exp_addr_q.push_back(addr);
         nxt = tx_br[i] ? tx_tgt[i] : addr + 32'd4;
         exp_acc_q.push_back('{instr: tx_data[i], next: nxt, retired: 32'(i)});
         addr = nxt;
      end

      pc_rst = 32'h0;
      @(posedge clk_i);
      #1;
      auto  = 1'b1;
      rst_i = 1'b1;
      done  = 1'b0;
      for (int k = 0; k < 3000 && !done; k++) begin
         @(negedge clk_i);
         if (n_acc >= NTX) done = 1'b1;
      end
      if (!done) check("run_timeout", n_acc, NTX);
      @(negedge clk_i);
      check("retired_final", retired_cnt_o, NTX);
      check("addr_q_empty", exp_addr_q.size(), 0);
      check("acc_q_empty", exp_acc_q.size(), 0);
      auto = 1'b0;
      imem_ack_i   = 1'b0;
      core_ready_i = 1'b0;
      branch_i     = 1'b0;

      // Misaligned PC: no request, sticky cause 01.
      do_reset(32'h0000_0006);
      @(posedge clk_i);
      @(negedge clk_i);
      check("misalign_no_req", imem_req_o, 0);
      check("misalign_fault_late", fault_o, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         check("misalign_fault", fault_o, 1);
         check("misalign_cause", fault_cause_o, 2'b01);
         check("misalign_pc_next", pc_next_o, pc_i);
      end

      // Ack never arrives: 5 request cycles then cause 10.
      do_reset(32'h0000_0100);
      cnt  = 0;
      done = 1'b0;
      for (int k = 0; k < 30 && !done; k++) begin
         @(negedge clk_i);
         if (imem_req_o) cnt++;
         if (fault_o) done = 1'b1;
      end
      check("timeout_req_cycles", cnt, 5);
      check("timeout_cause", fault_cause_o, 2'b10);
      check("timeout_valid", instr_valid_o, 0);
      @(negedge clk_i);
      check("timeout_sticky", fault_o, 1);
      check("timeout_no_req", imem_req_o, 0);

      // Reset mid-REQ drops the request; a late ack is ignored.
      do_reset(32'h0000_0200);
      @(negedge clk_i);
      @(negedge clk_i);
      check("midreq_req", imem_req_o, 1);
      check("midreq_addr", imem_addr_o, 32'h0000_0200);
      rst_i = 1'b0;
      #1;
      check("async_req_drop", imem_req_o, 0);
      check("async_addr_drop", imem_addr_o, 0);
      imem_ack_i   = 1'b1;
      imem_rdata_i = 32'hDEAD_BEEF;
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      imem_ack_i = 1'b0;
      @(negedge clk_i);
      check("late_ack_valid", instr_valid_o, 0);
      check("late_ack_instr", instr_o, 0);
      check("late_ack_req", imem_req_o, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
